uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Detects the receiver's level-held ready flag, captures the byte, and pulses the receiver's clear input to acknowledge it.
- Stores bytes in a first-word-fall-through FIFO read by the processor's memory-mapped UART port.
- Flags overrun when a byte arrives while the FIFO is full.

Parameters:
DATA_W, 8, byte width; matches the receiver output.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
rx_rdy  input  1  receiver byte-ready; level; held high until cleared.
rx_data  input  DATA_W  receiver byte; valid while rx_rdy=1.
rx_clear  output  1  acknowledge to the receiver's clear input; registered.
rd_en  input  1  pop strobe from the processor side.
rd_data  output  DATA_W  head of FIFO (FWFT); undefined when empty=1.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds 2**ADDR_W entries.
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
overrun  output  1  sticky; a byte was dropped because the FIFO was full.
ovr_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers and count go to 0.
  - State goes to IDLE; rx_clear=0; overrun=0.
  - empty=1, full=0.
  - Memory contents are not reset.
- Capture FSM, two states: IDLE and ACK.
  - IDLE, rx_rdy=1:
    - Latch rx_data.
    - Push if the push is accepted (see below); otherwise set overrun.
    - Next state ACK; rx_clear<=1.
  - IDLE, rx_rdy=0: stay; rx_clear=0.
  - ACK, rx_rdy=1: stay; rx_clear held at 1. The receiver drops ready one cycle after it samples clear.
  - ACK, rx_rdy=0: next state IDLE; rx_clear<=0.
  - Each ready assertion is pushed exactly once. No push occurs in ACK.
  - Nominal sequence: push at edge N; rx_clear high for edges N+1..N+2; IDLE again after edge N+2.
  - Latency: byte visible on rd_data with empty=0 in the cycle after the capturing edge.
- Push acceptance: a push is accepted if (!full) or (full and rd_en=1 in the same cycle).
  - In the full case, the pop and push both happen; count stays at max.
- Pop: rd_en=1 and empty=0 advances the read pointer. rd_en while empty is ignored, with no error flag.
- Simultaneous push and pop when not empty: count unchanged; both pointers advance.
- Simultaneous push and rd_en when empty: the push happens and the pop is ignored; count becomes 1.
- Pointers are ADDR_W bits and wrap modulo depth. count is maintained explicitly, with full = (count == 2**ADDR_W).
- FIFO memory read is combinational from the read pointer (FWFT). Writing the head entry is impossible while count>0.
- overrun:
  - Set on a rejected push.
  - ovr_clr clears it.
  - If ovr_clr and a rejected push occur in the same cycle, set wins.
- Reset mid-ACK: the FSM returns to IDLE and rx_clear drops. If rx_rdy is still high on the first cycle after reset, that byte is captured again (a duplicate is acceptable after reset).

Test Plan:
- Single byte: rx_rdy=1 with rx_data=0xA5, held until rx_clear seen plus one cycle -> count=1, rd_data=0xA5, rx_clear high exactly 2 cycles, one push only; rd_en pulse -> empty=1, count=0.
- Ordering and wrap: push 0x00..0x13 in 20 bytes while popping after every 4th byte -> read sequence strictly 0x00..0x13, pointers wrap past 15, no overrun.
- Full and overrun: push 16 bytes 0x10..0x1F with no reads -> full=1, count=16; push 0x77 -> overrun=1, count=16, head still 0x10; ovr_clr -> overrun=0.
- Full with simultaneous pop: FIFO full, push 0x88 in the same cycle as rd_en -> count=16, overrun=0, 0x88 read out last.
- Empty push+pop: empty FIFO, push 0x3C with rd_en=1 in the same cycle -> count=1, rd_data=0x3C.
- Reset mid-operation: rst_n=0 during ACK with 5 entries stored -> next cycle rx_clear=0, count=0, empty=1, overrun=0, state IDLE.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte capture with handshake and FWFT FIFO
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_clear,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state;
    state_t            next_state;
    logic              push_req;
    logic              clear_next;
    logic              do_push;
    logic              do_pop;
    logic              reject;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign rd_data = mem[rd_ptr];

    // A pop is only real when something is stored; when full, a same-cycle
    // pop frees the slot the incoming byte needs.
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || rd_en);
    assign reject  = push_req && full && !rd_en;

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state: hold ACK until the receiver drops its ready level
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rx_rdy)  next_state = ACK;
            ACK:     if (!rx_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: capture only on the IDLE->ACK transition, clear while in ACK
    always_comb begin
        push_req   = (state == IDLE) && rx_rdy;
        clear_next = (next_state == ACK);
    end

    // Registered acknowledge to the receiver
    always_ff @(posedge clk) begin
        if (!rst_n) rx_clear <= 1'b0;
        else        rx_clear <= clear_next;
    end

    // FIFO storage; not reset, the head is never overwritten while occupied
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_data;
    end

    // Pointers and explicit occupancy count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun; a rejected byte wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n)       overrun <= 1'b0;
        else if (reject)  overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_clear;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;

    int n_checks = 0;
    int n_errors = 0;
    int last_clr;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_clear(rx_clear), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every real pop presents the head, compare with the oldest expected byte
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_en === 1'b1 && empty === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_data: got 0x%0h with no byte expected", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_errors++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // Receiver model: hold ready until clear is sampled, drop it one cycle later
    task automatic send_byte(input logic [7:0] b, input bit store, input bit pop_with);
        int guard;
        int hi;
        rx_data = b;
        rx_rdy  = 1'b1;
        rd_en   = pop_with;
        if (store) exp_q.push_back(b);
        guard = 0;
        hi    = 0;
        do begin
            @(posedge clk); #1;
            rd_en = 1'b0;
            guard++;
        end while (!rx_clear && guard < 10);
        if (!rx_clear) begin
            check("rx_clear_timeout", 0, 1);
        end else begin
            hi = 1;
            @(posedge clk); #1;
            if (rx_clear) hi++;
            rx_rdy = 1'b0;
            @(posedge clk); #1;
            if (rx_clear) hi++;
        end
        last_clr = hi;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_count", int'(count), 0);
        check("reset_rx_clear", int'(rx_clear), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte handshake
        send_byte(8'hA5, 1'b1, 1'b0);
        check("single_clear_cycles", last_clr, 2);
        check("single_count", int'(count), 1);
        check("single_rd_data", int'(rd_data), 8'hA5);
        check("single_empty", int'(empty), 0);
        pop_one();
        check("single_pop_empty", int'(empty), 1);
        check("single_pop_count", int'(count), 0);

        // Ordering and pointer wrap
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            if (i % 4 == 3) repeat (4) pop_one();
        end
        check("wrap_overrun", int'(overrun), 0);
        check("wrap_empty", int'(empty), 1);

        // Fill, then overrun
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b0);
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);
        send_byte(8'h77, 1'b0, 1'b0);
        check("ovr_set", int'(overrun), 1);
        check("ovr_count", int'(count), 16);
        check("ovr_head", int'(rd_data), 8'h10);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);

        // Full with simultaneous pop: 0x10 leaves, 0x88 enters at the tail
        send_byte(8'h88, 1'b1, 1'b1);
        check("fullpop_count", int'(count), 16);
        check("fullpop_overrun", int'(overrun), 0);
        check("fullpop_head", int'(rd_data), 8'h11);
        repeat (16) pop_one();
        check("drain_empty", int'(empty), 1);

        // Empty push with rd_en in the same cycle
        send_byte(8'h3C, 1'b1, 1'b1);
        check("emptypop_count", int'(count), 1);
        check("emptypop_rd_data", int'(rd_data), 8'h3C);
        pop_one();

        // Reset while in ACK with 5 entries stored
        for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 1'b1, 1'b0);
        rx_data = 8'h54;
        rx_rdy  = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_count", int'(count), 5);
        check("pre_reset_clear", int'(rx_clear), 1);
        rst_n  = 1'b0;
        rx_rdy = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_rx_clear", int'(rx_clear), 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        send_byte(8'h42, 1'b1, 1'b0);
        check("post_rst_clear_cycles", last_clr, 2);
        check("post_rst_count", int'(count), 1);
        pop_one();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
